control_unit: RTL
=================

Name: control_unit

Overview:
- Multicycle control FSM that drives the processor's fetch/decode datapath.
- Consumes the 32-bit instruction word from the instruction ROM and the 6-bit flag vector from the register/ALU datapath.
- Produces WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load and select_flags. It is the initiator side of the datapath's control interface.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode retires as NOP (PC+1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instruction  input  32  current ROM output (dout)
- flags  input  6  datapath flags, used only for branch sanity/trap logic; branch choice is made by the datapath mux
- WE_mem  output  1  data memory write enable
- WE_reg  output  1  register bank write enable
- OP_MEM_I  output  2  writeback source: 00 ALU reg-reg, 01 ALU reg-imm, 10 memory load, 11 store path (no writeback)
- ADD_SUB  output  1  0 = add, 1 = subtract
- PC_load  output  1  PC register load strobe
- select_flags  output  3  next-PC flag select
- trap  output  1  high while in TRAP

Behaviour:
- Reset: asynchronous, active-high. State goes to FETCH. All outputs are 0, including trap. The latched instruction fields are cleared.
- Outputs are Moore-decoded from the registered state and the latched fields. Asserting reset mid-instruction therefore drops WE_mem, WE_reg and PC_load immediately, with no partial write after release.
- Latched fields: instruction[6:0], [14:12] and [30] are captured on the DECODE→EXEC edge. They stay stable until the next DECODE.
- Opcodes:
  - R = 0110011
  - I-ALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - JAL = 1101111
  - Anything else is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - FETCH: all strobes 0 (ROM settle). Next state DECODE.
  - DECODE: all strobes 0; fields latched. Next state EXEC, or TRAP/NOP for an illegal opcode.
  - EXEC: ADD_SUB, OP_MEM_I and select_flags are valid.
    - BRANCH and JAL assert PC_load here, then go to FETCH.
    - LOAD and STORE go to MEM.
    - R and I-ALU go to WB.
  - MEM:
    - STORE asserts WE_mem=1 and PC_load=1, then goes to FETCH.
    - LOAD keeps OP_MEM_I=10, then goes to WB.
  - WB: WE_reg=1 and PC_load=1 (one cycle). Next state FETCH.
  - TRAP: all strobes 0, trap=1. Exits only on reset.
- Latency per instruction: BRANCH/JAL 3 cycles; R, I-ALU and STORE 4 cycles; LOAD 5 cycles.
- Every strobe (WE_mem, WE_reg, PC_load) is exactly one cycle wide, at most once per instruction.
- ADD_SUB = 1 only for:
  - R-type with funct3=000 and instruction[30]=1 (SUB);
  - BRANCH (compare by subtract).
  - Otherwise 0.
- select_flags, held from EXEC through the end of the instruction:
  - 000: BEQ, zero
  - 001: BNE
  - 010: BLT
  - 011: BGE
  - 100: BLTU
  - 101: BGEU
  - 110: sequential (PC+1); used for every non-branch instruction
  - 111: JAL, forced jump
  - Branch funct3 010 and 011 are illegal.
- OP_MEM_I values: R → 00; I-ALU → 01; LOAD → 10; STORE, BRANCH and JAL → 11.
- Illegal opcode with TRAP_ON_ILLEGAL=0: DECODE→EXEC with select_flags=110, PC_load=1 in EXEC, then FETCH. No writes occur.

Optional Feature:
- Macro CU_RETIRE_COUNT_EN.
- Defined: adds output instr_retired [31:0].
  - Increments by 1 on every clock edge where PC_load=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Asynchronously cleared by reset.
  - Frozen in TRAP.
- Undefined: the port and the counter are absent; all other behaviour is unchanged.

Test Plan:
- Reset asserted mid-WB of an R-type → WE_reg and PC_load fall in the same cycle. After release: FETCH, and all outputs 0 for 2 cycles.
- instruction=0x40208033 (SUB x0,x1,x2) → EXEC shows ADD_SUB=1, OP_MEM_I=00, select_flags=110. WB shows WE_reg=1 and PC_load=1 on cycle 4; next FETCH on cycle 5.
- instruction=0x00012083 (LW) → MEM on cycle 4 with OP_MEM_I=10 and WE_mem=0. WB on cycle 5 with WE_reg=1 and PC_load=1.
- instruction=0x00112023 (SW) → MEM on cycle 4 with WE_mem=1, PC_load=1, WE_reg=0, OP_MEM_I=11.
- BNE 0x00209463 → EXEC on cycle 3 with select_flags=001, ADD_SUB=1, PC_load=1, no writes. JAL 0x0080006F → select_flags=111.
- Opcode 0x7F with TRAP_ON_ILLEGAL=1 → trap=1 from cycle 3 and stays high for 100 cycles with zero strobes. With TRAP_ON_ILLEGAL=0 → PC_load=1 in EXEC; with CU_RETIRE_COUNT_EN the counter increments by 1.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the fetch/decode datapath.
// Optional macro CU_RETIRE_COUNT_EN adds the instr_retired output and its counter.
module control_unit #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [5:0]  flags,
    output logic        WE_mem,
    output logic        WE_reg,
    output logic [1:0]  OP_MEM_I,
    output logic        ADD_SUB,
    output logic        PC_load,
    output logic [2:0]  select_flags,
    output logic        trap
`ifdef CU_RETIRE_COUNT_EN
    ,
    output logic [31:0] instr_retired
`endif
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;
    logic       bit30_q;
    logic       legal_now;
    logic       legal_q;
    logic       add_sub_d;
    logic [1:0] op_d;
    logic [2:0] sel_d;
    logic       unused_bits;

    function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_JAL: is_legal = 1'b1;
            OPC_BRANCH: is_legal = (f3 != 3'b010) && (f3 != 3'b011);
            default:    is_legal = 1'b0;
        endcase
    endfunction

    assign legal_now   = is_legal(instruction[6:0], instruction[14:12]);
    assign legal_q     = is_legal(opcode_q, funct3_q);
    assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7], flags};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Fields are captured on leaving DECODE and held for the rest of the instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q <= '0;
            funct3_q <= '0;
            bit30_q  <= 1'b0;
        end else if (state == DECODE) begin
            opcode_q <= instruction[6:0];
            funct3_q <= instruction[14:12];
            bit30_q  <= instruction[30];
        end
    end

    always_comb begin
        add_sub_d = 1'b0;
        op_d      = 2'b11;
        sel_d     = 3'b110;
        if (legal_q) begin
            case (opcode_q)
                OPC_R: begin
                    op_d      = 2'b00;
                    add_sub_d = (funct3_q == 3'b000) && bit30_q;
                end
                OPC_I:    op_d = 2'b01;
                OPC_LOAD: op_d = 2'b10;
                OPC_BRANCH: begin
                    add_sub_d = 1'b1;
                    // Compact the six legal branch funct3 codes onto select 000..101.
                    case (funct3_q)
                        3'b000:  sel_d = 3'b000;
                        3'b001:  sel_d = 3'b001;
                        3'b100:  sel_d = 3'b010;
                        3'b101:  sel_d = 3'b011;
                        3'b110:  sel_d = 3'b100;
                        default: sel_d = 3'b101;
                    endcase
                end
                OPC_JAL: sel_d = 3'b111;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        WE_mem       = 1'b0;
        WE_reg       = 1'b0;
        OP_MEM_I     = 2'b00;
        ADD_SUB      = 1'b0;
        PC_load      = 1'b0;
        select_flags = 3'b000;
        trap         = 1'b0;
        case (state)
            FETCH: state_next = DECODE;
            DECODE: begin
                if (legal_now || !TRAP_ON_ILLEGAL) begin
                    state_next = EXEC;
                end else begin
                    state_next = TRAP;
                end
            end
            EXEC: begin
                ADD_SUB      = add_sub_d;
                OP_MEM_I     = op_d;
                select_flags = sel_d;
                if (!legal_q || opcode_q == OPC_BRANCH || opcode_q == OPC_JAL) begin
                    PC_load    = 1'b1;
                    state_next = FETCH;
                end else if (opcode_q == OPC_LOAD || opcode_q == OPC_STORE) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                ADD_SUB      = add_sub_d;
                OP_MEM_I     = op_d;
                select_flags = sel_d;
                if (opcode_q == OPC_STORE) begin
                    WE_mem     = 1'b1;
                    PC_load    = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end
            WB: begin
                ADD_SUB      = add_sub_d;
                OP_MEM_I     = op_d;
                select_flags = sel_d;
                WE_reg       = 1'b1;
                PC_load      = 1'b1;
                state_next   = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    assert property (@(posedge clk) disable iff (reset)
        (state == EXEC && legal_q && opcode_q == OPC_BRANCH) |-> !$isunknown(flags));

`ifdef CU_RETIRE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_retired <= '0;
        end else if (PC_load) begin
            instr_retired <= instr_retired + 32'd1;
        end
    end
`else
    // No retire counter in this build.
`endif

endmodule
